dc_huffman_decoder: RTL
=======================

DC_HUFFMAN_DECODER -- requirements
Module: dc_huffman_decoder

Interface
REQ-001 SHALL have parameter CHROMA, default 0; 0 selects the luminance DC table, 1 selects the chrominance DC table.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_data, input, 8 bits: entropy-coded byte, MSB first.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data valid.
REQ-006 SHALL have port in_ready, output, 1 bit: byte accepted on a cycle with in_valid && in_ready.
REQ-007 SHALL have port out_diff, output, 12 bits: signed two's-complement DC difference.
REQ-008 SHALL have port out_cat, output, 4 bits: decoded category/size, 0..11.
REQ-009 SHALL have port out_valid, output, 1 bit: out_diff/out_cat valid.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed on a cycle with out_valid && out_ready.
REQ-011 SHALL have port err, output, 1 bit: one-cycle pulse on an invalid code or marker.

Function
REQ-012 SHALL use an 8-bit bit buffer with a bit count; in_ready = (count == 0) && !out_valid_pending_stall.
REQ-013 SHALL consume at most one bit per cycle, MSB first, starting the cycle after byte acceptance.
REQ-014 SHALL drop a 0x00 byte that immediately follows an accepted 0xFF (accept it, contribute no bits).
REQ-015 SHALL treat a non-zero byte following 0xFF as a marker: pulse err, discard both bytes and any partial symbol, return to CODE.
REQ-016 SHALL implement FSM states CODE, AMP and OUT.
REQ-017 CODE SHALL shift bits into a code register, with length +1 per bit, and compare against the CHROMA table (code, size).
REQ-018 On a match, SHALL latch the category; category 0 goes to OUT with diff 0, otherwise to AMP.
REQ-019 In CODE, a code with no match at length 9 (luma) or 11 (chroma) SHALL pulse err, clear the code register and stay in CODE.
REQ-020 AMP SHALL collect exactly category bits, then go to OUT.
REQ-021 Amplitude decoding: if the amplitude MSB is 1, diff = amplitude; if 0, diff = amplitude - (2^cat - 1); the result is sign-extended to 12 bits.
REQ-022 OUT SHALL assert out_valid with out_diff/out_cat stable until out_ready, then go to CODE on the same edge.
REQ-023 SHALL consume no bits while in OUT; the buffer holds and in_ready stays low if the buffer is not empty.
REQ-024 Latency: out_valid SHALL rise on the cycle after the last code/amplitude bit is consumed.
REQ-025 A symbol spanning a byte boundary SHALL resume on the first bit of the next byte with no lost bits.

Reset
REQ-026 While rst_n is low, SHALL reset FSM=CODE; buffer, count, code, length, amplitude = 0; stuffing flag cleared; in_ready=0, out_valid=0, out_diff=0, out_cat=0, err=0.
REQ-027 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-028 Reset mid-symbol SHALL discard all partial state; no output is produced for the aborted symbol.

Structure
REQ-029 The shared huffman package SHALL hold dcHuffman_t (11-bit code, 4-bit size) and the luma/chroma DC table constants, used by both encoder and decoder.
REQ-030 The byte/stuffing logic SHALL be a sub-module jpeg_bit_unpacker with a byte valid/ready input and a bit valid/ready output.

Verification
REQ-031 Luma, bytes 0x00 -> four outputs cat=0, diff=0.
REQ-032 Luma, byte 0x78 (011 11 000) -> cat=2 diff=+3, then cat=0 diff=0; the final bit waits for the next byte.
REQ-033 Luma, byte 0x60 (011 00 ...) -> cat=2 diff=-3.
REQ-034 Luma, bytes 0xFF,0x00,0x00,0x00 -> 0x00 stuffed byte accepted and dropped; cat=11 diff=-2047; then two cat=0 diff=0.
REQ-035 Luma, bytes 0xFF,0x00,0xFF,0x00 -> err pulses once at the 9th '1' bit; bytes 0xFF,0xD9 -> err, both bytes discarded.
REQ-036 Hold out_ready=0 for 5 cycles with out_valid=1 -> out_diff stable and no in_ready; then rst_n pulsed mid-AMP -> all outputs 0 and no stale output.

Source files
------------

// File: rtl/dc_huffman_decoder_pkg.sv
// Shared JPEG DC huffman definitions: table entry type, luma/chroma DC tables,
// code lookup and amplitude-to-difference helpers used by encoder and decoder.
package dc_huffman_decoder_pkg;

    typedef struct packed {
        logic [10:0] code;
        logic [3:0]  size;
    } dcHuffman_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] cat;
    } dc_match_t;

    typedef enum logic [1:0] {
        ST_CODE = 2'd0,
        ST_AMP  = 2'd1,
        ST_OUT  = 2'd2
    } dc_state_e;

    localparam int         DC_NUM_CAT       = 12;
    localparam logic [3:0] DC_LUMA_MAXLEN   = 4'd9;
    localparam logic [3:0] DC_CHROMA_MAXLEN = 4'd11;

    // Codes are right-aligned in the 11-bit field; index is the category.
    localparam dcHuffman_t DC_LUMA_TBL [DC_NUM_CAT] = '{
        '{11'b00,          4'd2},
        '{11'b010,         4'd3},
        '{11'b011,         4'd3},
        '{11'b100,         4'd3},
        '{11'b101,         4'd3},
        '{11'b110,         4'd3},
        '{11'b1110,        4'd4},
        '{11'b11110,       4'd5},
        '{11'b111110,      4'd6},
        '{11'b1111110,     4'd7},
        '{11'b11111110,    4'd8},
        '{11'b111111110,   4'd9}
    };

    localparam dcHuffman_t DC_CHROMA_TBL [DC_NUM_CAT] = '{
        '{11'b00,          4'd2},
        '{11'b01,          4'd2},
        '{11'b10,          4'd2},
        '{11'b110,         4'd3},
        '{11'b1110,        4'd4},
        '{11'b11110,       4'd5},
        '{11'b111110,      4'd6},
        '{11'b1111110,     4'd7},
        '{11'b11111110,    4'd8},
        '{11'b111111110,   4'd9},
        '{11'b1111111110,  4'd10},
        '{11'b11111111110, 4'd11}
    };

    function automatic dc_match_t dc_lookup(input logic        chroma,
                                            input logic [10:0] code,
                                            input logic [3:0]  len);
        dc_match_t  m;
        dcHuffman_t e;
        m = '0;
        for (int i = 0; i < DC_NUM_CAT; i++) begin
            e = chroma ? DC_CHROMA_TBL[i] : DC_LUMA_TBL[i];
            if (e.size == len && e.code == code) begin
                m.hit = 1'b1;
                m.cat = 4'(i);
            end
        end
        return m;
    endfunction

    // Leading 0 in the amplitude means a negative difference (one's-complement form).
    function automatic logic [11:0] dc_amp_to_diff(input logic [10:0] amp,
                                                   input logic [3:0]  cat);
        logic [11:0] a;
        logic [11:0] span;
        a    = {1'b0, amp};
        span = (12'd1 << cat) - 12'd1;
        if (cat == 4'd0) begin
            return 12'd0;
        end
        if (amp[cat - 4'd1]) begin
            return a;
        end
        return a - span;
    endfunction

endpackage

// File: rtl/jpeg_bit_unpacker.sv
// Byte-to-bit unpacker with 0xFF00 stuffing removal and marker detection.
// Latency: first bit offered the cycle after byte acceptance, one bit per cycle.
// Backpressure: byte_rdy only when the buffer is empty and hold is low; bits wait on bit_rdy.
module jpeg_bit_unpacker (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_dat,
    input  logic       byte_vld,
    output logic       byte_rdy,
    input  logic       hold,
    output logic       bit_dat,
    output logic       bit_vld,
    input  logic       bit_rdy,
    output logic       marker_vld
);

    logic [7:0] buf_q,   buf_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       stuff_q, stuff_d;
    logic       run_q;
    logic       byte_fire;

    assign byte_rdy   = run_q && (cnt_q == 4'd0) && !hold;
    assign byte_fire  = byte_vld && byte_rdy;
    assign bit_vld    = (cnt_q != 4'd0);
    assign bit_dat    = buf_q[7];
    assign marker_vld = byte_fire && stuff_q && (byte_dat != 8'h00);

    always_comb begin
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        stuff_d = stuff_q;
        if (byte_fire) begin
            if (stuff_q) begin
                // Byte after 0xFF never carries data: either stuffing or a marker.
                stuff_d = 1'b0;
            end else begin
                buf_d   = byte_dat;
                cnt_d   = 4'd8;
                stuff_d = (byte_dat == 8'hFF);
            end
        end else if (bit_vld && bit_rdy) begin
            buf_d = {buf_q[6:0], 1'b0};
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q   <= 8'd0;
            cnt_q   <= 4'd0;
            stuff_q <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            stuff_q <= stuff_d;
            run_q   <= 1'b1;
        end
    end

endmodule

// File: rtl/dc_huffman_decoder.sv
// JPEG DC coefficient huffman decoder: bytes in, (category, signed difference) out.
// Latency: out_valid rises the cycle after the last code/amplitude bit is consumed.
// Backpressure: holds result until out_ready; no bits or bytes consumed while a result waits.
module dc_huffman_decoder
    import dc_huffman_decoder_pkg::*;
#(
    parameter int CHROMA = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [11:0] out_diff,
    output logic [3:0]  out_cat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err
);

    localparam logic       IS_CHROMA = (CHROMA != 0);
    localparam logic [3:0] MAXLEN    = IS_CHROMA ? DC_CHROMA_MAXLEN : DC_LUMA_MAXLEN;

    dc_state_e   state_q, state_d;
    logic [10:0] code_q,  code_d;
    logic [3:0]  len_q,   len_d;
    logic [3:0]  cat_q,   cat_d;
    logic [10:0] amp_q,   amp_d;
    logic [3:0]  acnt_q,  acnt_d;
    logic [11:0] diff_q,  diff_d;
    logic        err_q,   err_d;

    logic        bit_dat, bit_vld, bit_rdy, bit_fire, marker_vld;
    logic [10:0] code_sh, amp_sh;
    logic [3:0]  len_inc, acnt_inc;
    dc_match_t   lk;

    jpeg_bit_unpacker u_unpack (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_dat   (in_data),
        .byte_vld   (in_valid),
        .byte_rdy   (in_ready),
        .hold       (out_valid),
        .bit_dat    (bit_dat),
        .bit_vld    (bit_vld),
        .bit_rdy    (bit_rdy),
        .marker_vld (marker_vld)
    );

    assign bit_fire = bit_vld && bit_rdy;
    assign code_sh  = {code_q[9:0], bit_dat};
    assign len_inc  = len_q + 4'd1;
    assign amp_sh   = {amp_q[9:0], bit_dat};
    assign acnt_inc = acnt_q + 4'd1;
    assign lk       = dc_lookup(IS_CHROMA, code_sh, len_inc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_CODE;
            code_q  <= 11'd0;
            len_q   <= 4'd0;
            cat_q   <= 4'd0;
            amp_q   <= 11'd0;
            acnt_q  <= 4'd0;
            diff_q  <= 12'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            len_q   <= len_d;
            cat_q   <= cat_d;
            amp_q   <= amp_d;
            acnt_q  <= acnt_d;
            diff_q  <= diff_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        len_d   = len_q;
        cat_d   = cat_q;
        amp_d   = amp_q;
        acnt_d  = acnt_q;
        diff_d  = diff_q;
        err_d   = 1'b0;
        if (marker_vld) begin
            // A marker can only arrive with the bit buffer empty, so no bit is in flight.
            state_d = ST_CODE;
            code_d  = 11'd0;
            len_d   = 4'd0;
            amp_d   = 11'd0;
            acnt_d  = 4'd0;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                ST_CODE: begin
                    if (bit_fire) begin
                        if (lk.hit) begin
                            cat_d  = lk.cat;
                            code_d = 11'd0;
                            len_d  = 4'd0;
                            amp_d  = 11'd0;
                            acnt_d = 4'd0;
                            if (lk.cat == 4'd0) begin
                                diff_d  = 12'd0;
                                state_d = ST_OUT;
                            end else begin
                                state_d = ST_AMP;
                            end
                        end else if (len_inc == MAXLEN) begin
                            err_d  = 1'b1;
                            code_d = 11'd0;
                            len_d  = 4'd0;
                        end else begin
                            code_d = code_sh;
                            len_d  = len_inc;
                        end
                    end
                end
                ST_AMP: begin
                    if (bit_fire) begin
                        amp_d  = amp_sh;
                        acnt_d = acnt_inc;
                        if (acnt_inc == cat_q) begin
                            diff_d  = dc_amp_to_diff(amp_sh, cat_q);
                            state_d = ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_d = ST_CODE;
                    end
                end
                default: begin
                    state_d = ST_CODE;
                end
            endcase
        end
    end

    always_comb begin
        out_valid = (state_q == ST_OUT);
        bit_rdy   = (state_q != ST_OUT);
        out_diff  = diff_q;
        out_cat   = cat_q;
        err       = err_q;
    end

endmodule
